// File: rtl/serpent_pkg.sv
// Shared constants for the Serpent-128 decryption datapath: FSM encoding,
// round/key-index constants and the eight inverse S-box tables.
package serpent_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int         ROUNDS         = 32;
    localparam logic [5:0] LT_APPLY       = 6'd32;
    localparam logic [5:0] KEY_IDX_WHITEN = 6'd32;

    // SBOX_INV[b][v]: inverse of S-box b applied to nibble v
    localparam logic [3:0] SBOX_INV [8][16] = '{
        '{4'hD, 4'h3, 4'hB, 4'h0, 4'hA, 4'h6, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hF, 4'h9, 4'h8, 4'h2},
        '{4'h5, 4'h8, 4'h2, 4'hE, 4'hF, 4'h6, 4'hC, 4'h3, 4'hB, 4'h4, 4'h7, 4'h9, 4'h1, 4'hD, 4'hA, 4'h0},
        '{4'hC, 4'h9, 4'hF, 4'h4, 4'hB, 4'hE, 4'h1, 4'h2, 4'h0, 4'h3, 4'h6, 4'hD, 4'h5, 4'h8, 4'hA, 4'h7},
        '{4'h0, 4'h9, 4'hA, 4'h7, 4'hB, 4'hE, 4'h6, 4'hD, 4'h3, 4'h5, 4'hC, 4'h2, 4'h4, 4'h8, 4'hF, 4'h1},
        '{4'h5, 4'h0, 4'h8, 4'h3, 4'hA, 4'h9, 4'h7, 4'hE, 4'h2, 4'hC, 4'hB, 4'h6, 4'h4, 4'hF, 4'hD, 4'h1},
        '{4'h8, 4'hF, 4'h2, 4'h9, 4'h4, 4'h1, 4'hD, 4'hE, 4'hB, 4'h6, 4'h5, 4'h3, 4'h7, 4'hC, 4'hA, 4'h0},
        '{4'hF, 4'hA, 4'h1, 4'hD, 4'h5, 4'h3, 4'h6, 4'h0, 4'h4, 4'h9, 4'hE, 4'h7, 4'h2, 4'hC, 4'h8, 4'hB},
        '{4'h3, 4'h0, 4'h6, 4'hD, 4'h9, 4'hE, 4'hF, 4'h8, 4'h5, 4'hC, 4'hB, 4'h7, 4'hA, 4'h1, 4'h4, 4'h2}
    };

endpackage

// File: rtl/serpent_sbox_inv.sv
// Bitsliced inverse Serpent S-box: bit j of words X3..X0 forms one nibble
// (X0 is the LSB) that is mapped through inverse box box_i.
module serpent_sbox_inv
    import serpent_pkg::*;
(
    input  logic [127:0] data_i,
    input  logic [2:0]   box_i,
    output logic [127:0] data_o
);

    for (genvar j = 0; j < 32; j++) begin : g_slice
        logic [3:0] nib;
        assign nib = SBOX_INV[box_i][{data_i[j], data_i[32+j], data_i[64+j], data_i[96+j]}];
        assign {data_o[j], data_o[32+j], data_o[64+j], data_o[96+j]} = nib;
    end

endmodule

// File: rtl/serpent_dec_core.sv
// Iterative Serpent-128 decryption: whitening on accept, then 32 inverse
// rounds one per cycle using an external key schedule and inverse-LT stage.
module serpent_dec_core
    import serpent_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    output logic [5:0]   o_key_idx,
    input  logic [127:0] i_key,
    output logic [127:0] o_lt_data,
    output logic [5:0]   o_lt_round,
    input  logic [127:0] i_lt_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data
);

    state_e       state_q, state_d;
    logic [127:0] x_q, x_d;
    logic [4:0]   r_q, r_d;
    logic [127:0] sbox_in;
    logic [127:0] sbox_out;

    // The first inverse round has no LT in front of it
    assign sbox_in = (r_q == 5'd31) ? x_q : i_lt_data;

    serpent_sbox_inv u_sbox_inv (
        .data_i (sbox_in),
        .box_i  (r_q[2:0]),
        .data_o (sbox_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    x_d     = i_data ^ i_key;
                    r_d     = 5'(ROUNDS - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = sbox_out ^ i_key;
                if (r_q == 5'd0) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q - 5'd1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready    = (state_q == IDLE);
        o_valid    = (state_q == DONE);
        o_data     = x_q;
        o_lt_data  = x_q;
        o_key_idx  = KEY_IDX_WHITEN;
        o_lt_round = 6'd0;
        if (state_q == RUN) begin
            o_key_idx  = {1'b0, r_q};
            o_lt_round = (r_q == 5'd31) ? 6'd0 : LT_APPLY;
        end
    end

endmodule

// File: tb/tb_serpent_dec_core.sv
// Bench for serpent_dec_core: forward Serpent model builds ciphertexts, a
// scoreboard queue holds the expected plaintexts.
module tb_serpent_dec_core;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic [127:0] i_data = '0;
    logic         o_ready, o_valid;
    logic [127:0] i_key, i_lt_data, o_lt_data, o_data;
    logic [5:0]   o_key_idx, o_lt_round;

    logic [127:0] rk [64];
    logic [127:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    localparam logic [3:0] SB [8][16] = '{
        '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
        '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
        '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
        '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
        '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
        '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
        '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
        '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
    };

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] lt(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = x;
        a = rol(a, 13); c = rol(c, 3);
        b = b ^ a ^ c;  d = d ^ c ^ (a << 3);
        b = rol(b, 1);  d = rol(d, 7);
        a = a ^ b ^ d;  c = c ^ d ^ (b << 7);
        a = rol(a, 5);  c = rol(c, 22);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] lt_inv(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = x;
        c = rol(c, 10); a = rol(a, 27);
        c = c ^ d ^ (b << 7); a = a ^ b ^ d;
        d = rol(d, 25); b = rol(b, 31);
        d = d ^ c ^ (a << 3); b = b ^ a ^ c;
        c = rol(c, 29); a = rol(a, 19);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] sb_fwd(input logic [2:0] box, input logic [127:0] x);
        logic [127:0] y;
        logic [3:0]   n;
        y = '0;
        for (int j = 0; j < 32; j++) begin
            n = SB[box][{x[j], x[32+j], x[64+j], x[96+j]}];
            {y[j], y[32+j], y[64+j], y[96+j]} = n;
        end
        return y;
    endfunction

    function automatic logic [127:0] sb_inv(input logic [2:0] box, input logic [127:0] x);
        logic [127:0] y;
        logic [3:0]   nin, n;
        y = '0;
        for (int j = 0; j < 32; j++) begin
            nin = {x[j], x[32+j], x[64+j], x[96+j]};
            n = 4'h0;
            for (int v = 0; v < 16; v++) if (SB[box][v] == nin) n = 4'(v);
            {y[j], y[32+j], y[64+j], y[96+j]} = n;
        end
        return y;
    endfunction

    function automatic logic [127:0] enc_model(input logic [127:0] p);
        logic [127:0] x;
        x = p;
        for (int i = 0; i < 32; i++) begin
            x = sb_fwd(3'(i), x ^ rk[i]);
            if (i < 31) x = lt(x);
            else        x = x ^ rk[32];
        end
        return x;
    endfunction

    function automatic logic [127:0] dec_model(input logic [127:0] c);
        logic [127:0] x;
        x = sb_inv(3'd7, c ^ rk[32]) ^ rk[31];
        for (int r = 30; r >= 0; r--) x = sb_inv(3'(r), lt_inv(x)) ^ rk[r];
        return x;
    endfunction

    // Neighbouring blocks: key schedule lookup and inverse-LT stage
    assign i_key     = rk[o_key_idx];
    assign i_lt_data = (o_lt_round == 6'd32) ? lt_inv(o_lt_data) : o_lt_data;

    serpent_dec_core dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_key_idx  (o_key_idx),
        .i_key      (i_key),
        .o_lt_data  (o_lt_data),
        .o_lt_round (o_lt_round),
        .i_lt_data  (i_lt_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge i_clk);
    endtask

    // Drive one block at a negedge where o_ready is high; returns at T1
    task automatic start(input logic [127:0] c, input logic [127:0] p);
        i_data  = c;
        i_valid = 1'b1;
        exp_q.push_back(p);
        tick();
        i_valid = 1'b0;
        i_data  = ~c;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_key_idx !== 6'd32 || o_lt_round !== 6'd0)
            begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got rdy=%0b vld=%0b idx=%0d ltr=%0d want 1 0 32 0",
                         k, o_ready, o_valid, o_key_idx, o_lt_round);
            end
            checks++;
            if (o_data !== 128'h0 || o_lt_data !== 128'h0) begin
                errors++;
                $display("FAIL reset_data cyc%0d: got %h / %h want 0", k, o_data, o_lt_data);
            end
        end
    endtask

    task automatic test_zero();
        logic [127:0] want;
        for (int i = 0; i < 64; i++) rk[i] = '0;
        i_ready = 1'b1;
        checks++;
        if (o_key_idx !== 6'd32 || o_lt_round !== 6'd0) begin
            errors++;
            $display("FAIL zero_T0: got idx=%0d ltr=%0d want 32 0", o_key_idx, o_lt_round);
        end
        start(128'h0, dec_model(128'h0));
        for (int k = 1; k <= 33; k++) begin
            if (k <= 32) begin
                checks++;
                if (o_key_idx !== 6'(32 - k)) begin
                    errors++;
                    $display("FAIL zero_key_idx T%0d: got %0d want %0d", k, o_key_idx, 32 - k);
                end
                checks++;
                if (o_lt_round !== ((k == 1) ? 6'd0 : 6'd32)) begin
                    errors++;
                    $display("FAIL zero_lt_round T%0d: got %0d want %0d", k, o_lt_round,
                             (k == 1) ? 0 : 32);
                end
                checks++;
                if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_run_hs T%0d: got vld=%0b rdy=%0b want 0 0", k, o_valid, o_ready);
                end
            end else begin
                checks++;
                if (o_valid !== 1'b1 || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL zero_valid T33: got %0b want 1", o_valid);
                end else begin
                    want = exp_q.pop_front();
                    checks++;
                    if (o_data !== want) begin
                        errors++;
                        $display("FAIL zero_data: got %h want %h", o_data, want);
                    end
                end
            end
            tick();
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_idle_T34: got rdy=%0b want 1", o_ready);
        end
    endtask

    task automatic test_known_answer();
        logic [127:0] pt [2];
        logic [127:0] want;
        int lat;
        for (int i = 0; i < 33; i++) rk[i] = {$urandom, $urandom, $urandom, $urandom};
        pt[0] = 128'h00112233445566778899aabbccddeeff;
        pt[1] = 128'hfedcba98765432100123456789abcdef;
        for (int b = 0; b < 2; b++) begin
            start(enc_model(pt[b]), pt[b]);
            lat = 1;
            while (o_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL kat_latency blk%0d: got %0d want 33", b, lat);
            end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                if (o_data !== want) begin
                    errors++;
                    $display("FAIL kat_data blk%0d: got %h want %h", b, o_data, want);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pa, pb, want;
        int lat;
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        i_ready = 1'b0;
        start(enc_model(pa), pa);
        lat = 1;
        while (o_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        i_valid = 1'b1;
        i_data  = enc_model(pb);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== pa) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: got vld=%0b rdy=%0b data=%h want 1 0 %h",
                         k, o_valid, o_ready, o_data, pa);
            end
            tick();
        end
        i_ready = 1'b1;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            checks++;
            if (o_data !== want) begin
                errors++;
                $display("FAIL bp_data_a: got %h want %h", o_data, want);
            end
        end
        tick();
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle_after_ready: got rdy=%0b want 1", o_ready);
        end
        start(enc_model(pb), pb);
        lat = 1;
        while (o_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL bp_latency_b: got %0d want 33", lat);
        end
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            checks++;
            if (o_data !== want) begin
                errors++;
                $display("FAIL bp_data_b: got %h want %h", o_data, want);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [127:0] pa, pb, want;
        int n, lat;
        pa = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        pb = 128'h13579bdf02468ace13579bdf02468ace;
        start(enc_model(pa), pa);
        n = 1;
        while (o_key_idx !== 6'd17 && n < 40) begin tick(); n++; end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL rst_mid_reach_r17: got T%0d want T15", n);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_key_idx !== 6'd32 || o_lt_round !== 6'd0 ||
            o_data !== 128'h0 || o_lt_data !== 128'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got rdy=%0b vld=%0b idx=%0d ltr=%0d data=%h lt=%h want 1 0 32 0 0 0",
                     o_ready, o_valid, o_key_idx, o_lt_round, o_data, o_lt_data);
        end
        exp_q.delete();
        tick();
        i_rst = 1'b0;
        tick();
        start(enc_model(pb), pb);
        lat = 1;
        while (o_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL rst_mid_latency: got %0d want 33", lat);
        end
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            checks++;
            if (o_data !== want) begin
                errors++;
                $display("FAIL rst_mid_data: got %h want %h", o_data, want);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt [3];
        logic [127:0] want;
        int acc [3];
        int outc [3];
        int na, no;
        na = 0;
        no = 0;
        for (int b = 0; b < 3; b++) begin
            pt[b]   = {$urandom, $urandom, $urandom, $urandom};
            acc[b]  = -1;
            outc[b] = -1;
        end
        i_ready = 1'b1;
        for (int n = 0; n < 150 && no < 3; n++) begin
            i_valid = (na < 3);
            if (o_valid === 1'b1) begin
                outc[no] = n;
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    checks++;
                    if (o_data !== want) begin
                        errors++;
                        $display("FAIL b2b_data blk%0d: got %h want %h", no, o_data, want);
                    end
                end
                no++;
            end
            if (o_ready === 1'b1 && na < 3) begin
                i_data = enc_model(pt[na]);
                exp_q.push_back(pt[na]);
                acc[na] = n;
                na++;
            end
            tick();
        end
        i_valid = 1'b0;
        checks++;
        if (no !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs want 3", no);
        end
        for (int b = 0; b < 3; b++) begin
            if (b > 0) begin
                checks++;
                if (acc[b] - acc[0] !== 34 * b) begin
                    errors++;
                    $display("FAIL b2b_accept blk%0d: got T%0d want T%0d", b, acc[b] - acc[0], 34 * b);
                end
            end
            checks++;
            if (outc[b] - acc[0] !== 33 + 34 * b) begin
                errors++;
                $display("FAIL b2b_valid blk%0d: got T%0d want T%0d", b, outc[b] - acc[0], 33 + 34 * b);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rk[i] = '0;
        i_rst = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;
        test_reset();
        test_zero();
        test_known_answer();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serpent_dec_core.md
# serpent_dec_core

Iterative Serpent-128 block decryption engine for the XTS datapath. Accepts one 128-bit ciphertext block over a valid/ready handshake, fetches round keys by index from the key schedule, and runs 32 decryption iterations, one per cycle. On every iteration it drives the neighbouring inverse linear-transform stage and consumes its result. It returns the plaintext over a second valid/ready handshake. It sits between the XTS tweak-XOR front end and the tweak-XOR back end.

## Interface
- No parameters. Rounds fixed at 32, block width fixed at 128.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  ciphertext valid.
- o_ready  out  1  core can accept a block.
- i_data  in  128  ciphertext; word X0 = [127:96], X1 = [95:64], X2 = [63:32], X3 = [31:0].
- o_key_idx  out  6  round-key index requested this cycle (0..32).
- i_key  in  128  round key K[o_key_idx], same word layout; combinational, same cycle.
- o_lt_data  out  128  state presented to the inverse-LT stage.
- o_lt_round  out  6  6'd32 = apply inverse LT; any other value = pass through.
- i_lt_data  in  128  inverse-LT stage result (combinational return).
- o_valid  out  1  plaintext valid.
- i_ready  in  1  downstream accepts plaintext.
- o_data  out  128  plaintext, same word layout.

## Operation
- FSM states:
  - IDLE: o_ready = 1, o_key_idx = 32. On i_valid & o_ready: X <= i_data ^ i_key, r <= 31, go to RUN.
  - RUN, r = 31: X <= SboxInv_7(X) ^ K31. o_lt_round = 0 (pass through).
  - RUN, r = 30..0: X <= SboxInv_(r mod 8)(i_lt_data) ^ K_r, with o_lt_data = X and o_lt_round = 32.
  - RUN exit: after r = 0, go to DONE. Otherwise r <= r - 1.
  - DONE: o_valid = 1, o_data = X. On i_ready, go to IDLE.
- Datapath routing:
  - o_lt_data = X in every state.
  - o_key_idx = {1'b0, r} in RUN.
  - S-box input at r = 31 comes from X. All other rounds take it from i_lt_data.
- Inverse S-box is bitsliced. For each bit j in 0..31, the nibble {X3[j], X2[j], X1[j], X0[j]} (X0 = LSB) maps through the inverse table. Example: SboxInv_0 = 13,3,11,0,10,6,5,12,1,14,4,7,15,9,8,2.
- Counter r is 5 bits and down-counts. No wrap occurs, because exit happens at r = 0.
- Input handshake:
  - o_ready is low outside IDLE, so i_valid there is ignored.
  - i_data is sampled only in the accept cycle.
- Output handshake:
  - While o_valid & !i_ready, o_data is held stable indefinitely.
  - o_valid never drops without a handshake.
- Reset is asserted asynchronously at any time, including mid-RUN or in DONE:
  - state -> IDLE, X -> 0, r -> 0.
  - The in-flight block is discarded.
  - Outputs take reset values immediately.
- Reset values: o_ready = 1, o_valid = 0, o_data = 0, o_key_idx = 32, o_lt_data = 0, o_lt_round = 0.

## Timing
- Accept at cycle T0.
- RUN occupies T1..T32, with key index 31 at T1 down to 0 at T32.
- o_valid is high from T33.
- Latency is 33 cycles from accept to o_valid.
- If i_ready is high at T33, the state is IDLE at T34 and the next accept can happen at T34. Peak throughput is one block per 34 cycles.
- The key path (o_key_idx -> i_key) and the LT path (o_lt_data -> i_lt_data) are combinational within one cycle.
- All outputs are registered-state decodes with no i_valid/i_ready -> output comb paths, except that the accept decision uses i_valid.

## Structure
- Package serpent_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - ROUNDS = 32;
  - LT_APPLY = 6'd32;
  - KEY_IDX_WHITEN = 6'd32;
  - eight 4-bit inverse S-box tables.
- Sub-module serpent_sbox_inv: combinational. Inputs are 128-bit data and a 3-bit box select; it applies the bitsliced inverse S-box. Share it with the key-schedule verification model.

## Test plan
- Reset, then idle 5 cycles -> o_ready = 1, o_valid = 0, o_key_idx = 32, o_lt_round = 0 throughout.
- Single block, i_data = 128'h0, i_key returned as 128'h0 for all indices, i_ready = 1:
  - o_key_idx sequence is 32, 31, 30, ..., 0 on T0..T32;
  - o_lt_round = 0 at T0/T1 and 32 on T2..T32;
  - o_valid at T33;
  - o_data matches the golden C model.
- Known-answer: a published Serpent-128 vector with its expanded key schedule served by index -> plaintext matches the vector exactly.
- Backpressure: i_ready low for 10 cycles after o_valid -> o_data stable, o_ready = 0, a second i_valid is ignored. Raise i_ready -> IDLE next cycle, second block accepted.
- Reset asserted asynchronously mid-RUN at r = 17 -> all outputs at reset values within the same cycle. The next block after reset decrypts correctly with 33-cycle latency.
- Back-to-back: i_valid held high with i_ready = 1 for 3 blocks -> accepts at T0, T34, T68; o_valid pulses at T33, T67, T101.
